// File: rtl/sram_block_buffer.sv
// Byte-wide SRAM responder for the AES SRAM controllers.
// Packs read bytes into blocks and serializes result blocks into byte writes.
module sram_block_buffer #(
  parameter int ADDR_BITS   = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     r_en,
  input  logic                     w_en,
  input  logic [ADDR_BITS-1:0]     addr,
  input  logic                     pl_en,
  input  logic [ADDR_BITS-1:0]     pl_addr,
  input  logic [7:0]               pl_data,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [8*BLOCK_BYTES-1:0] blk_out,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  input  logic [8*BLOCK_BYTES-1:0] blk_in,
  input  logic                     blk_in_valid,
  output logic                     blk_in_ready,
  output logic                     err
);

  localparam int BW    = 8 * BLOCK_BYTES;
  localparam int CW    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

  localparam logic [0:0] W_EMPTY  = 1'b0;
  localparam logic [0:0] W_LOADED = 1'b1;

  logic [7:0] mem_q [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [7:0]           mem_wdata;

  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [BW-1:0] blk_out_q, blk_out_d;
  logic          blk_valid_q, blk_valid_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [0:0]    w_state_q, w_state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [BW-1:0] wsh_q, wsh_d;
  logic          err_q, err_d;

  logic wr_err;
  logic rd_drop;

  // Write port arbitration, read launch and serializer FSM.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = pl_addr;
    mem_wdata  = pl_data;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    w_state_d  = w_state_q;
    wcnt_d     = wcnt_q;
    wsh_d      = wsh_q;
    wr_err     = 1'b0;

    if (w_en) begin
      if (w_state_q == W_LOADED) begin
        mem_we    = 1'b1;
        mem_waddr = addr;
        mem_wdata = wsh_q[BW-1 -: 8];
        wsh_d     = wsh_q << 8;
        if (wcnt_q == LAST) begin
          wcnt_d    = '0;
          w_state_d = W_EMPTY;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end else begin
        wr_err = 1'b1;
      end
      if (pl_en || r_en) begin
        wr_err = 1'b1;
      end
    end else begin
      if (pl_en) begin
        mem_we = 1'b1;
      end
      if (r_en) begin
        rd_data_d  = mem_q[addr];
        rd_valid_d = 1'b1;
      end
    end

    if ((w_state_q == W_EMPTY) && blk_in_valid) begin
      wsh_d     = blk_in;
      wcnt_d    = '0;
      w_state_d = W_LOADED;
    end
  end

  // Read assembler: a full block stalls new bytes until the handshake.
  always_comb begin
    blk_out_d   = blk_out_q;
    blk_valid_d = blk_valid_q;
    rcnt_d      = rcnt_q;
    rd_drop     = 1'b0;

    if (blk_valid_q && blk_ready) begin
      blk_valid_d = 1'b0;
    end

    if (rd_valid_q) begin
      if (blk_valid_q && !blk_ready) begin
        rd_drop = 1'b1;
      end else begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (rcnt_q == CW'(i)) begin
            blk_out_d[BW-1-8*i -: 8] = rd_data_q;
          end
        end
        if (rcnt_q == LAST) begin
          rcnt_d      = '0;
          blk_valid_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_d = err_q | wr_err | rd_drop;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      blk_out_q   <= '0;
      blk_valid_q <= 1'b0;
      rcnt_q      <= '0;
      w_state_q   <= W_EMPTY;
      wcnt_q      <= '0;
      wsh_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      blk_out_q   <= blk_out_d;
      blk_valid_q <= blk_valid_d;
      rcnt_q      <= rcnt_d;
      w_state_q   <= w_state_d;
      wcnt_q      <= wcnt_d;
      wsh_q       <= wsh_d;
      err_q       <= err_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign blk_out      = blk_out_q;
  assign blk_valid    = blk_valid_q;
  assign blk_in_ready = (w_state_q == W_EMPTY);
  assign err          = err_q;

endmodule

// File: tb/tb_sram_block_buffer.sv
// Bench for sram_block_buffer: read-data scoreboard plus
// table-driven readback and hand-written corner sequences.
module tb_sram_block_buffer;

  logic         clk;
  logic         n_rst;
  logic         r_en;
  logic         w_en;
  logic [7:0]   addr;
  logic         pl_en;
  logic [7:0]   pl_addr;
  logic [7:0]   pl_data;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_in;
  logic         blk_in_valid;
  logic         blk_in_ready;
  logic         err;

  sram_block_buffer #(.ADDR_BITS(8), .BLOCK_BYTES(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .r_en         (r_en),
    .w_en         (w_en),
    .addr         (addr),
    .pl_en        (pl_en),
    .pl_addr      (pl_addr),
    .pl_data      (pl_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .blk_out      (blk_out),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_in       (blk_in),
    .blk_in_valid (blk_in_valid),
    .blk_in_ready (blk_in_ready),
    .err          (err)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } sb_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  sb_t  sb[$];
  sb_t  e;
  vec_t vec[16];
  int   checks;
  int   failures;
  int   cyc;

  localparam logic [127:0] BLK_A = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK_W = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] BLK_C = 128'h3C4D5E6F718293A4B5C6D7E8F9012345;
  localparam logic [127:0] BLK_R = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Read-data scoreboard: each read expects its byte exactly one cycle later.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL rd_missing: no rd_valid at cycle %0d, required data %h",
               sb[0].cyc, sb[0].data);
      void'(sb.pop_front());
    end
    if (rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got rd_valid data %h at cycle %0d, required none",
                 rd_data, cyc);
      end else begin
        e = sb.pop_front();
        if (e.data !== rd_data || e.cyc != cyc) begin
          failures++;
          $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d",
                   rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pl(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] x);
    r_en = 1'b1;
    addr = a;
    sb.push_back('{data: x, cyc: cyc + 1});
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a);
    w_en = 1'b1;
    addr = a;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic load_blk(input logic [127:0] b);
    blk_in = b;
    blk_in_valid = 1'b1;
    @(negedge clk);
    blk_in_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_data"}, 128'(rd_data), 128'h0);
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'h0);
    chk({tag, "_blk_out"}, blk_out, 128'h0);
    chk({tag, "_blk_valid"}, 128'(blk_valid), 128'h0);
    chk({tag, "_blk_in_ready"}, 128'(blk_in_ready), 128'h1);
    chk({tag, "_err"}, 128'(err), 128'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) begin
      vec[i].addr = 8'(8'h40 + i);
      vec[i].exp  = 8'(8'hFF - 8'h11 * i);
    end

    n_rst = 1'b0;
    r_en = 1'b0;
    w_en = 1'b0;
    addr = 8'h00;
    pl_en = 1'b0;
    pl_addr = 8'h00;
    pl_data = 8'h00;
    blk_ready = 1'b0;
    blk_in = '0;
    blk_in_valid = 1'b0;
    idle(2);
    chk_reset("reset");
    n_rst = 1'b1;

    for (int i = 0; i < 16; i++) pl(8'(i), 8'(i));
    for (int i = 0; i < 16; i++) pl(8'(8'hA0 + i), 8'(8'hA0 + i));
    for (int i = 0; i < 16; i++) pl(8'(8'h40 + i), 8'h11);
    pl(8'h20, 8'h5A);
    pl(8'h21, 8'h6B);
    pl(8'h30, 8'h77);
    pl(8'h51, 8'h00);

    // Assemble one block from back-to-back reads.
    for (int i = 0; i < 16; i++) rd(8'(i), 8'(i));
    chk("blk_valid_early", 128'(blk_valid), 128'h0);
    idle(1);
    chk("blk_valid_full", 128'(blk_valid), 128'h1);
    chk("blk_out_full", blk_out, BLK_A);
    chk("err_clean_read", 128'(err), 128'h0);

    // Byte while stalled is dropped.
    rd(8'h05, 8'h05);
    idle(1);
    chk("err_drop", 128'(err), 128'h1);
    chk("blk_out_held", blk_out, BLK_A);
    chk("blk_valid_held", 128'(blk_valid), 128'h1);
    blk_ready = 1'b1;
    idle(1);
    blk_ready = 1'b0;
    chk("blk_valid_consumed", 128'(blk_valid), 128'h0);

    // Block serialization.
    rst_pulse();
    chk("err_after_rst", 128'(err), 128'h0);
    load_blk(BLK_W);
    chk("blk_in_ready_loaded", 128'(blk_in_ready), 128'h0);
    for (int i = 0; i < 16; i++) begin
      wr(8'(8'h40 + i));
      if (i == 7) chk("blk_in_ready_mid", 128'(blk_in_ready), 128'h0);
    end
    chk("blk_in_ready_done", 128'(blk_in_ready), 128'h1);
    chk("err_clean_write", 128'(err), 128'h0);

    for (int i = 0; i < 16; i++) rd(vec[i].addr, vec[i].exp);
    idle(1);
    chk("blk_out_writeback", blk_out, BLK_W);
    blk_ready = 1'b1;
    idle(1);
    blk_ready = 1'b0;

    // Write strobe with nothing to serialize.
    wr(8'h30);
    chk("err_w_empty", 128'(err), 128'h1);
    chk("blk_in_ready_w_empty", 128'(blk_in_ready), 128'h1);
    rd(8'h30, 8'h77);
    idle(1);

    // Read, write and preload in the same cycle.
    rst_pulse();
    chk("err_after_rst2", 128'(err), 128'h0);
    load_blk(BLK_C);
    r_en = 1'b1;
    w_en = 1'b1;
    addr = 8'h20;
    pl_en = 1'b1;
    pl_addr = 8'h21;
    pl_data = 8'hEE;
    @(negedge clk);
    r_en = 1'b0;
    w_en = 1'b0;
    pl_en = 1'b0;
    chk("rd_valid_conflict", 128'(rd_valid), 128'h0);
    chk("err_conflict", 128'(err), 128'h1);
    rd(8'h20, 8'h3C);
    rd(8'h21, 8'h6B);
    wr(8'h51);
    rd(8'h51, 8'h4D);
    idle(2);
    chk("blk_in_ready_partial", 128'(blk_in_ready), 128'h0);

    // Reset in the middle of an assembly.
    rst_pulse();
    for (int i = 0; i < 7; i++) rd(8'(i), 8'(i));
    idle(2);
    n_rst = 1'b0;
    @(negedge clk);
    chk_reset("mid_reset");
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 16; i++) rd(8'(8'hA0 + i), 8'(8'hA0 + i));
    idle(1);
    chk("blk_valid_fresh", 128'(blk_valid), 128'h1);
    chk("blk_out_fresh", blk_out, BLK_R);
    chk("err_fresh", 128'(err), 128'h0);

    idle(3);
    chk("sb_drained", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
